twiddle_rom_arbiter: RTL and testbench

//   Shares one single-port twiddle/sine ROM (1-cycle registered read, enable + address in, dout out)

---
 rtl/twiddle_rom_arbiter_if.sv | 30 +++
 rtl/twiddle_rom_arbiter.sv | 155 +++++++++++++++
 tb/tb_twiddle_rom_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/twiddle_rom_arbiter_if.sv
// Requester-side bundle of the twiddle ROM arbiter: request handshake
// plus the registered response strobe.
interface twiddle_rom_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int MEM_WIDTH = 16,
    parameter int MEM_DEPTH = 21
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic                  rsp_err;
    logic [MEM_WIDTH-1:0]  rsp_data;

    // butterfly address generators
    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_data
    );

    // arbiter
    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_id, rsp_err, rsp_data
    );
endinterface

// File: rtl/twiddle_rom_arbiter.sv
// Round-robin arbiter sharing one single-port twiddle ROM between NTT
// butterfly requesters. Grants come in bursts of up to BURST_MAX, the next
// owner is searched in the same cycle a burst ends, and out-of-range
// addresses are answered with an error instead of reaching the ROM.
//
// state    | meaning
// ST_IDLE  | no owner; search from r_ptr on any valid request
// ST_BURST | r_owner holds the ROM, r_cnt grants given in this burst
module twiddle_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MEM_WIDTH = 16,
    parameter int MEM_DEPTH = 21,
    parameter int BURST_MAX = 4,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    twiddle_rom_arbiter_if.slave bus,
    output logic                 o_rom_enable,
    output logic [AW-1:0]        o_rom_address,
    input  logic [MEM_WIDTH-1:0] i_rom_dout
);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(BURST_MAX);
    localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(MEM_DEPTH);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t        r_state, w_state_n;
    logic [IW-1:0] r_owner, w_owner_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [IW-1:0] r_ptr, w_ptr_n;

    logic          r_rsp_valid;
    logic [IW-1:0] r_rsp_id;
    logic          r_rsp_err;

    logic          w_hit;
    logic [IW-1:0] w_gidx;
    logic [IW:0]   w_search;
    logic          w_grant;
    logic [AW-1:0] w_addr;
    logic          w_err;

    // Circular priority scan: {hit, index} of first valid at or after start.
    function automatic logic [IW:0] f_search(input logic [NUM_REQ-1:0] valid,
                                             input logic [IW-1:0]      start);
        int j;
        f_search = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(start) + k) % NUM_REQ;
            if (valid[j]) f_search = {1'b1, IW'(j)};
        end
    endfunction

    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
        f_next = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_n;
            r_owner <= w_owner_n;
            r_cnt   <= w_cnt_n;
            r_ptr   <= w_ptr_n;
        end
    end

    // Next-state and grant selection; a burst end re-searches in the same cycle.
    always_comb begin
        w_state_n = r_state;
        w_owner_n = r_owner;
        w_cnt_n   = r_cnt;
        w_ptr_n   = r_ptr;
        w_hit     = 1'b0;
        w_gidx    = '0;
        w_search  = '0;
        case (r_state)
            ST_IDLE: begin
                w_search = f_search(bus.req_valid, r_ptr);
                if (w_search[IW]) begin
                    w_hit     = 1'b1;
                    w_gidx    = w_search[IW-1:0];
                    w_owner_n = w_search[IW-1:0];
                    w_cnt_n   = CW'(1);
                    w_state_n = ST_BURST;
                end
            end
            ST_BURST: begin
                if (bus.req_valid[r_owner] && (r_cnt < CNT_MAX)) begin
                    w_hit   = 1'b1;
                    w_gidx  = r_owner;
                    w_cnt_n = r_cnt + 1'b1;
                end else begin
                    w_ptr_n  = f_next(r_owner);
                    w_search = f_search(bus.req_valid, f_next(r_owner));
                    if (w_search[IW]) begin
                        w_hit     = 1'b1;
                        w_gidx    = w_search[IW-1:0];
                        w_owner_n = w_search[IW-1:0];
                        w_cnt_n   = CW'(1);
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Grant decode, address mux and range trap toward the ROM.
    always_comb begin
        w_grant = w_hit & ~i_reset;
        w_addr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gidx == IW'(i)) w_addr = bus.req_addr[i*AW +: AW];
        end
        w_err = ({1'b0, w_addr} >= DEPTH_LIM);
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = w_grant && (w_gidx == IW'(i));
        end
        o_rom_enable  = w_grant & ~w_err;
        o_rom_address = o_rom_enable ? w_addr : '0;
    end

    // Response pipeline, aligned with the ROM's one-cycle read.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_grant;
            r_rsp_id    <= w_grant ? w_gidx : '0;
            r_rsp_err   <= w_grant & w_err;
        end
    end

    // Response outputs; a response due while reset is high is dropped.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = r_rsp_valid && ~i_reset && (r_rsp_id == IW'(i));
        end
        bus.rsp_id   = i_reset ? '0 : r_rsp_id;
        bus.rsp_err  = r_rsp_err & ~i_reset;
        bus.rsp_data = (r_rsp_valid && !r_rsp_err && !i_reset) ? i_rom_dout : '0;
    end
endmodule

// File: tb/tb_twiddle_rom_arbiter.sv
// Bench for twiddle_rom_arbiter: directed scenarios followed by randomized
// requesters, all checked against a rule-level model of the arbitration.
module tb_twiddle_rom_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int D  = 21;
    localparam int BM = 4;
    localparam int AW = 5;
    localparam int IW = 2;

    logic          clk;
    logic          reset;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_q;
    logic [W-1:0]  mem [0:D-1];

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    bit       m_busy;
    int       m_owner, m_run, m_ptr;
    bit       p_valid, p_err;
    int       p_id;
    logic [W-1:0] p_data;

    twiddle_rom_arbiter_if #(.NUM_REQ(N), .MEM_WIDTH(W), .MEM_DEPTH(D)) bus ();

    twiddle_rom_arbiter #(.NUM_REQ(N), .MEM_WIDTH(W), .MEM_DEPTH(D), .BURST_MAX(BM)) dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .bus          (bus),
        .o_rom_enable (rom_en),
        .o_rom_address(rom_addr),
        .i_rom_dout   (rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port ROM with registered read
    always @(posedge clk) if (rom_en) rom_q <= mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_run = 0; m_ptr = 0;
        p_valid = 0; p_err = 0; p_id = 0; p_data = '0;
    endtask

    // One cycle: drive, check against the model, advance the model. g = granted index or -1.
    task automatic step(input bit rst, input logic [N-1:0] v, input logic [N*AW-1:0] a, output int g);
        bit hit, cont, err;
        int gi, start, addr;
        @(negedge clk);
        reset = rst;
        bus.req_valid = v;
        bus.req_addr  = a;
        #1;
        hit = 0; cont = 0; gi = 0;
        if (!rst) begin
            if (m_busy && v[m_owner] && m_run < BM) begin
                hit = 1; cont = 1; gi = m_owner;
            end else begin
                start = m_busy ? (m_owner + 1) % N : m_ptr;
                for (int k = 0; k < N; k++) begin
                    if (!hit && v[(start + k) % N]) begin
                        hit = 1; gi = (start + k) % N;
                    end
                end
            end
        end
        addr = hit ? int'(a[gi*AW +: AW]) : 0;
        err  = hit && (addr >= D);
        chk("req_ready",   32'(bus.req_ready), hit ? (32'd1 << gi) : 32'd0);
        chk("rom_enable",  32'(rom_en), 32'(hit && !err));
        chk("rom_address", 32'(rom_addr), (hit && !err) ? 32'(addr) : 32'd0);
        chk("rsp_valid",   32'(bus.rsp_valid), (!rst && p_valid) ? (32'd1 << p_id) : 32'd0);
        chk("rsp_id",      32'(bus.rsp_id), (!rst && p_valid) ? 32'(p_id) : 32'd0);
        chk("rsp_err",     32'(bus.rsp_err), 32'(!rst && p_valid && p_err));
        chk("rsp_data",    32'(bus.rsp_data), (!rst && p_valid) ? 32'(p_data) : 32'd0);
        if (rst) begin
            model_reset();
        end else begin
            if (cont) begin
                m_run++;
            end else begin
                if (m_busy) m_ptr = (m_owner + 1) % N;
                if (hit) begin
                    m_owner = gi; m_run = 1; m_busy = 1;
                end else begin
                    m_busy = 0;
                end
            end
            p_valid = hit;
            p_id    = hit ? gi : 0;
            p_err   = err;
            p_data  = (hit && !err) ? mem[addr] : '0;
        end
        g = hit ? gi : -1;
    endtask

    initial begin : main
        int g;
        bit rv [N];
        logic [AW-1:0] ra [N];
        logic [N-1:0] v;
        logic [N*AW-1:0] a;
        logic [W-1:0] t2_words [3];

        for (int i = 0; i < D; i++) mem[i] = 16'h1000 + 16'(i * 16'h0123);
        mem[0] = 16'h1fdf; mem[1] = 16'h1bff; mem[2] = 16'h0aff;
        t2_words[0] = 16'h1fdf; t2_words[1] = 16'h1bff; t2_words[2] = 16'h0aff;
        model_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;

        // reset held with every requester valid
        for (int i = 0; i < 3; i++) step(1, 4'hF, '0, g);

        // single requester 2, addresses 0..2
        for (int i = 0; i < 4; i++) begin
            a = '0;
            a[2*AW +: AW] = AW'(i);
            step(0, (i < 3) ? 4'b0100 : 4'b0000, a, g);
            if (i < 3) chk("t2_grant", 32'(g), 32'd2);
            if (i > 0) chk("t2_data", 32'(bus.rsp_data), 32'(t2_words[i-1]));
        end

        // all valid: bursts of BURST_MAX rotating through owners
        step(1, '0, '0, g);
        for (int i = 0; i < 12; i++) begin
            step(0, 4'hF, {5'd3, 5'd2, 5'd1, 5'd0}, g);
            chk("t3_grant", 32'(g), 32'((i / BM) % N));
        end

        // owner drops out mid-burst; next owner without an idle cycle
        step(1, '0, '0, g);
        step(0, 4'b1010, {5'd7, 5'd0, 5'd4, 5'd0}, g); chk("t4_g0", 32'(g), 32'd1);
        step(0, 4'b1010, {5'd7, 5'd0, 5'd5, 5'd0}, g); chk("t4_g1", 32'(g), 32'd1);
        step(0, 4'b1000, {5'd8, 5'd0, 5'd0, 5'd0}, g); chk("t4_g2", 32'(g), 32'd3);
        step(0, 4'b0000, '0, g);

        // out-of-range address trapped
        step(1, '0, '0, g);
        step(0, 4'b0001, {15'd0, 5'd21}, g);
        chk("t5_rom_en", 32'(rom_en), 32'd0);
        step(0, 4'b0000, '0, g);
        chk("t5_rsp_err",   32'(bus.rsp_err), 32'd1);
        chk("t5_rsp_data",  32'(bus.rsp_data), 32'd0);
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'b0001);

        // reset right after a grant drops the response and clears ptr
        step(1, '0, '0, g);
        step(0, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, g);
        step(0, 4'b0100, {5'd0, 5'd3, 5'd0, 5'd0}, g);
        step(1, 4'b0110, '0, g);
        chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step(0, 4'b0110, {5'd0, 5'd1, 5'd6, 5'd0}, g);
        chk("t6_grant", 32'(g), 32'd1);

        // randomized requesters holding requests until accepted
        step(1, '0, '0, g);
        for (int i = 0; i < N; i++) begin rv[i] = 0; ra[i] = '0; end
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1;
                    ra[i] = AW'($urandom_range(0, 23));
                end
                v[i] = rv[i];
                a[i*AW +: AW] = ra[i];
            end
            if ($urandom_range(0, 249) == 0) begin
                step(1, v, a, g);
                for (int i = 0; i < N; i++) rv[i] = 0;
            end else begin
                step(0, v, a, g);
                if (g >= 0) begin
                    rv[g] = ($urandom_range(0, 1) == 1);
                    ra[g] = AW'($urandom_range(0, 23));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
